// File: rtl/holy_core_pkg.sv
// Shared types for the debug-module AXI-Lite master bridge.
package holy_core_pkg;

  typedef enum logic [2:0] {
    M_IDLE,
    M_WRITE,
    M_BRESP,
    M_READ,
    M_RDATA,
    M_DONE
  } dm_axi_master_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/dm_sba_to_axi_lite.sv
// SBA initiator to AXI-Lite master bridge, one outstanding transaction.
// Optional stall watchdog built when DM_AXI_TIMEOUT_EN is defined.
//
// state   | meaning
// M_IDLE  | waiting for a host request; only state that grants
// M_WRITE | AW and W offered, each dropped after its own handshake
// M_BRESP | waiting for the write response
// M_READ  | AR offered until accepted
// M_RDATA | waiting for the read beat
// M_DONE  | one-cycle completion pulse to the host
module dm_sba_to_axi_lite
  import holy_core_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          host_req_i,
  input  logic                          host_we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     host_addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   host_be_i,
  input  logic [AXI_DATA_WIDTH-1:0]     host_wdata_i,
  output logic                          host_gnt_o,
  output logic                          host_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]     host_rdata_o,
  output logic                          host_err_o,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr_o,
  output logic [2:0]                    m_axi_awprot_o,
  output logic                          m_axi_awvalid_o,
  input  logic                          m_axi_awready_i,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb_o,
  output logic                          m_axi_wvalid_o,
  input  logic                          m_axi_wready_i,
  input  logic [1:0]                    m_axi_bresp_i,
  input  logic                          m_axi_bvalid_i,
  output logic                          m_axi_bready_o,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr_o,
  output logic [2:0]                    m_axi_arprot_o,
  output logic                          m_axi_arvalid_o,
  input  logic                          m_axi_arready_i,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata_i,
  input  logic [1:0]                    m_axi_rresp_i,
  input  logic                          m_axi_rvalid_i,
  output logic                          m_axi_rready_o
);

  localparam int BW = AXI_DATA_WIDTH / 8;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  dm_axi_master_state_t state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BW-1:0]             be_q, be_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic gnt;
  logic aw_hs, w_hs;
  logic resp_live;

  assign gnt   = host_req_i && (state_q == M_IDLE);
  assign aw_hs = awvalid_q && m_axi_awready_i;
  assign w_hs  = wvalid_q && m_axi_wready_i;

`ifdef DM_AXI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          orphan_q, orphan_d;
  logic          busy;
  logic          tmo_hit;

  assign busy    = (state_q == M_WRITE) || (state_q == M_BRESP) ||
                   (state_q == M_READ)  || (state_q == M_RDATA);
  assign tmo_hit = busy && !orphan_q && (tmo_cnt_q == '0);
  // Once the host has been told the access failed, the late response is discarded.
  assign resp_live = !orphan_q && !tmo_hit;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    orphan_d  = orphan_q;
    if (gnt) begin
      tmo_cnt_d = TW'(TIMEOUT_CYCLES - 1);
      orphan_d  = 1'b0;
    end else begin
      if ((state_q != M_IDLE) && (tmo_cnt_q != '0)) tmo_cnt_d = tmo_cnt_q - TW'(1);
      if (tmo_hit) orphan_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      orphan_q  <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      orphan_q  <= orphan_d;
    end
  end

  assign host_r_valid_o = ((state_q == M_DONE) && !orphan_q) || tmo_hit;
  assign host_rdata_o   = tmo_hit ? '0 : rdata_q;
  assign host_err_o     = tmo_hit || err_q;
`else
  assign resp_live      = 1'b1;
  assign host_r_valid_o = (state_q == M_DONE);
  assign host_rdata_o   = rdata_q;
  assign host_err_o     = err_q;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    unique case (state_q)
      M_IDLE: begin
        if (gnt) begin
          addr_d  = host_addr_i;
          wdata_d = host_wdata_i;
          be_d    = host_be_i;
          if (host_we_i) begin
            state_d   = M_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = M_READ;
            arvalid_d = 1'b1;
          end
        end
      end
      M_WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = M_BRESP;
      end
      M_BRESP: begin
        if (m_axi_bvalid_i) begin
          if (resp_live) begin
            err_d   = (m_axi_bresp_i != AXI_RESP_OKAY);
            rdata_d = '0;
          end
          state_d = M_DONE;
        end
      end
      M_READ: begin
        if (m_axi_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = M_RDATA;
        end
      end
      M_RDATA: begin
        if (m_axi_rvalid_i) begin
          if (resp_live) begin
            rdata_d = m_axi_rdata_i;
            err_d   = (m_axi_rresp_i != AXI_RESP_OKAY);
          end
          state_d = M_DONE;
        end
      end
      M_DONE: state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= M_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign host_gnt_o      = gnt;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awprot_o  = 3'b000;
  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = be_q;
  assign m_axi_wvalid_o  = wvalid_q;
  assign m_axi_bready_o  = (state_q == M_BRESP);
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arprot_o  = 3'b000;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_rready_o  = (state_q == M_RDATA);

endmodule
